// File: rtl/hog_frame_sequencer.sv
// rtl/hog_frame_sequencer.sv - frame load / scaler kick / completion sequencer for the HOG pipeline
module hog_frame_sequencer #(
    parameter int RAM_AW  = 17,
    parameter int P_WIDTH = 8,
    parameter int IMG_W   = 136,
    parameter int IMG_H   = 136,
    parameter int TMO_W   = 24
) (
    input  logic               aclk,
    input  logic               arest_n,
    input  logic               go,
    input  logic               abort,
    input  logic [P_WIDTH-1:0] s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tlast,
    output logic [3:0]         init_ena,
    output logic [3:0]         init_wea,
    output logic [RAM_AW-1:0]  init_addra,
    output logic [P_WIDTH-1:0] init_dina,
    output logic               start,
    input  logic               scaling_finish,
    input  logic               write_feature_done,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state,
    output logic [1:0]         err
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_KICK       = 3'd2,
        S_WAIT_SCALE = 3'd3,
        S_WAIT_HOG   = 3'd4,
        S_DONE       = 3'd5,
        S_ERR        = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    // Word address r*(IMG_W/4)+c/4, advanced once per group of four columns
    logic [RAM_AW-1:0]   word_q, word_d;
    // Final pixel accepted; hold in LOAD until its bank write is on the bus
    logic                last_q, last_d;
    // write_feature_done seen before scaling_finish
    logic                wfd_q, wfd_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [1:0]          err_q, err_d;
    logic [3:0]          ena_q, ena_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic [P_WIDTH-1:0]  din_q, din_d;

    logic                hs;
    logic                final_pix;
    logic [TMO_W-1:0]    tmo_inc;
    logic                tmo_hit;

    // Decoded handshake/status outputs; abort suppresses any write or start in its cycle
    always_comb begin
        s_tready   = (state_q == S_LOAD) && !last_q && !abort;
        hs         = s_tready && s_tvalid;
        final_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);
        start      = (state_q == S_KICK) && !abort;
        done       = (state_q == S_DONE);
        busy       = (state_q == S_LOAD) || (state_q == S_KICK) ||
                     (state_q == S_WAIT_SCALE) || (state_q == S_WAIT_HOG);
        init_ena   = ena_q & {4{!abort}};
        init_wea   = ena_q & {4{!abort}};
        init_addra = addr_q;
        init_dina  = din_q;
        state      = state_q;
        err        = err_q;
        tmo_inc    = tmo_q + TMO_W'(1);
        tmo_hit    = &tmo_inc;
    end

    // Next-state, counter and bank-write computation
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        word_d  = word_q;
        last_d  = last_q;
        wfd_d   = wfd_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ena_d   = 4'b0000;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (go) begin
                    state_d = S_LOAD;
                    err_d   = 2'b00;
                    col_d   = '0;
                    row_d   = '0;
                    word_d  = '0;
                    last_d  = 1'b0;
                    wfd_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (last_q) begin
                    state_d = S_KICK;
                    last_d  = 1'b0;
                end else if (hs) begin
                    ena_d  = 4'b0001 << col_q[1:0];
                    addr_d = word_q;
                    din_d  = s_tdata;
                    if (col_q[1:0] == 2'b11) begin
                        word_d = word_q + RAM_AW'(1);
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (s_tlast != final_pix) begin
                        err_d[0] = 1'b1;
                        state_d  = S_ERR;
                    end else if (final_pix) begin
                        last_d = 1'b1;
                    end
                end
            end
            S_KICK: begin
                state_d = S_WAIT_SCALE;
                tmo_d   = '0;
                wfd_d   = 1'b0;
            end
            S_WAIT_SCALE: begin
                tmo_d = tmo_inc;
                if (write_feature_done) begin
                    wfd_d = 1'b1;
                end
                if (scaling_finish) begin
                    state_d = (wfd_q || write_feature_done) ? S_DONE : S_WAIT_HOG;
                end else if (tmo_hit) begin
                    err_d[1] = 1'b1;
                    state_d  = S_ERR;
                end
            end
            S_WAIT_HOG: begin
                tmo_d = tmo_inc;
                if (write_feature_done || wfd_q) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    err_d[1] = 1'b1;
                    state_d  = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            err_d   = err_q;
            ena_d   = 4'b0000;
            addr_d  = addr_q;
            din_d   = din_q;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            wfd_q   <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 2'b00;
            ena_q   <= 4'b0000;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            word_q  <= word_d;
            last_q  <= last_d;
            wfd_q   <= wfd_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ena_q   <= ena_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_hog_frame_sequencer.sv
// tb/tb_hog_frame_sequencer.sv - self-checking bench for hog_frame_sequencer
module tb_hog_frame_sequencer;

    localparam int AW   = 17;
    localparam int PW   = 8;
    localparam int W    = 136;
    localparam int H    = 136;
    localparam int NPIX = W * H;
    localparam int BW   = 8;
    localparam int BH   = 2;
    localparam int BPIX = BW * BH;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          a_rst_n, a_go, a_abort, a_tvalid, a_tready, a_tlast;
    logic          a_start, a_sf, a_wfd, a_busy, a_done;
    logic [PW-1:0] a_tdata, a_din;
    logic [3:0]    a_ena, a_wea;
    logic [AW-1:0] a_addr;
    logic [2:0]    a_state;
    logic [1:0]    a_err;

    logic          b_rst_n, b_go, b_abort, b_tvalid, b_tready, b_tlast;
    logic          b_start, b_sf, b_wfd, b_busy, b_done;
    logic [PW-1:0] b_tdata, b_din;
    logic [3:0]    b_ena, b_wea;
    logic [AW-1:0] b_addr;
    logic [2:0]    b_state;
    logic [1:0]    b_err;

    hog_frame_sequencer #(.RAM_AW(AW), .P_WIDTH(PW), .IMG_W(W), .IMG_H(H), .TMO_W(24)) dut_a (
        .aclk(aclk), .arest_n(a_rst_n), .go(a_go), .abort(a_abort),
        .s_tdata(a_tdata), .s_tvalid(a_tvalid), .s_tready(a_tready), .s_tlast(a_tlast),
        .init_ena(a_ena), .init_wea(a_wea), .init_addra(a_addr), .init_dina(a_din),
        .start(a_start), .scaling_finish(a_sf), .write_feature_done(a_wfd),
        .busy(a_busy), .done(a_done), .state(a_state), .err(a_err)
    );

    hog_frame_sequencer #(.RAM_AW(AW), .P_WIDTH(PW), .IMG_W(BW), .IMG_H(BH), .TMO_W(4)) dut_b (
        .aclk(aclk), .arest_n(b_rst_n), .go(b_go), .abort(b_abort),
        .s_tdata(b_tdata), .s_tvalid(b_tvalid), .s_tready(b_tready), .s_tlast(b_tlast),
        .init_ena(b_ena), .init_wea(b_wea), .init_addra(b_addr), .init_dina(b_din),
        .start(b_start), .scaling_finish(b_sf), .write_feature_done(b_wfd),
        .busy(b_busy), .done(b_done), .state(b_state), .err(b_err)
    );

    typedef struct packed {
        logic [3:0]    ena;
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks      = 0;
    int  errors      = 0;
    int  a_start_cnt = 0;
    int  b3a33       = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation of DUT A: start pulses and bank writes against the scoreboard
    task automatic mon();
        wr_t e;
        if (a_start === 1'b1) a_start_cnt++;
        if (a_ena !== 4'b0000 || a_wea !== 4'b0000) begin
            if (a_ena === 4'b1000 && a_addr === AW'(33)) b3a33 = int'(a_din);
            checks++;
            if (exp_q.size() == 0) begin
                assert (a_ena === 4'b0000) else begin
                    errors++;
                    $error("FAIL unexpected_write ena=%b addr=%0d expected ena=0000", a_ena, a_addr);
                end
            end else begin
                e = exp_q.pop_front();
                assert ({a_ena, a_wea, a_addr, a_din} === {e.ena, e.ena, e.addr, e.data}) else begin
                    errors++;
                    $error("FAIL bank_write ena=%b wea=%b addr=%0d data=%0d expected ena=%b addr=%0d data=%0d",
                           a_ena, a_wea, a_addr, a_din, e.ena, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge aclk);
        mon();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_a(input int i, input bit last, input bit push);
        bit  hs;
        wr_t e;
        int  c;
        int  r;
        hs = 1'b0;
        c  = i % W;
        r  = i / W;
        a_tdata  = PW'(i % 256);
        a_tvalid = 1'b1;
        a_tlast  = last;
        for (int k = 0; k < 4 && !hs; k++) begin
            @(negedge aclk);
            mon();
            if (a_tready === 1'b1) begin
                hs = 1'b1;
                if (push) begin
                    e.ena  = 4'(1 << (c % 4));
                    e.addr = AW'(r * (W / 4) + c / 4);
                    e.data = PW'(i % 256);
                    exp_q.push_back(e);
                end
            end
            @(posedge aclk);
            #1;
        end
        chk("a_handshake", 32'(hs), 32'd1);
    endtask

    task automatic send_b(input int i, input bit last);
        bit hs;
        hs = 1'b0;
        b_tdata  = PW'(i % 256);
        b_tvalid = 1'b1;
        b_tlast  = last;
        for (int k = 0; k < 4 && !hs; k++) begin
            @(negedge aclk);
            mon();
            if (b_tready === 1'b1) hs = 1'b1;
            @(posedge aclk);
            #1;
        end
        chk("b_handshake", 32'(hs), 32'd1);
    endtask

    task automatic wait_a(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (a_state !== st && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(a_state), 32'(st));
    endtask

    task automatic wait_b(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (b_state !== st && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(b_state), 32'(st));
    endtask

    initial begin
        int n;
        a_rst_n = 0; a_go = 0; a_abort = 0; a_tvalid = 0; a_tlast = 0; a_tdata = '0; a_sf = 0; a_wfd = 0;
        b_rst_n = 0; b_go = 0; b_abort = 0; b_tvalid = 0; b_tlast = 0; b_tdata = '0; b_sf = 0; b_wfd = 0;
        repeat (3) @(posedge aclk);
        #1;
        a_rst_n = 1;
        b_rst_n = 1;

        // Reset state
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_outputs", 32'({a_busy, a_tready, a_start, a_done, a_err, a_ena, a_wea}), 32'd0);
        chk("rst_addr_data", 32'({a_addr, a_din}), 32'd0);

        // Full frame, then scaling_finish followed by write_feature_done
        a_go = 1; cyc(); a_go = 0;
        chk("t1_load", 32'(a_state), 32'd1);
        chk("t1_busy", 32'(a_busy), 32'd1);
        for (int i = 0; i < NPIX; i++) send_a(i, i == NPIX - 1, 1'b1);
        a_tvalid = 0; a_tlast = 0;
        wait_a("t1_wait_scale", 3'd3, 10);
        chk("t1_start_once", 32'(a_start_cnt), 32'd1);
        chk("t1_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_bank3_addr33", 32'(b3a33), 32'd135);
        a_sf = 1; cyc(); a_sf = 0;
        chk("t1_wait_hog", 32'(a_state), 32'd4);
        a_wfd = 1; cyc(); a_wfd = 0;
        chk("t1_done_state", 32'(a_state), 32'd5);
        chk("t1_done_pulse", 32'(a_done), 32'd1);
        cyc();
        chk("t1_idle", 32'(a_state), 32'd0);
        chk("t1_done_low", 32'(a_done), 32'd0);
        chk("t1_not_busy", 32'(a_busy), 32'd0);

        // Early tlast on pixel 100
        a_go = 1; cyc(); a_go = 0;
        for (int i = 0; i <= 100; i++) send_a(i, i == 100, 1'b1);
        a_tvalid = 0; a_tlast = 0;
        chk("t2_err_state", 32'(a_state), 32'd6);
        chk("t2_err_len", 32'(a_err), 32'd1);
        cyc(); cyc();
        chk("t2_pixel100_written", 32'(exp_q.size()), 32'd0);
        chk("t2_no_start", 32'(a_start_cnt), 32'd1);
        chk("t2_stay_err", 32'(a_state), 32'd6);
        chk("t2_no_ready", 32'(a_tready), 32'd0);

        // Go from ERR, then coincident completion pulses
        a_go = 1; cyc(); a_go = 0;
        chk("t3_load_from_err", 32'(a_state), 32'd1);
        chk("t3_err_cleared", 32'(a_err), 32'd0);
        for (int i = 0; i < NPIX; i++) send_a(i, i == NPIX - 1, 1'b1);
        a_tvalid = 0; a_tlast = 0;
        wait_a("t3_wait_scale", 3'd3, 10);
        chk("t3_start_once", 32'(a_start_cnt), 32'd2);
        a_sf = 1; a_wfd = 1; cyc(); a_sf = 0; a_wfd = 0;
        chk("t3_skip_hog", 32'(a_state), 32'd5);
        chk("t3_done_pulse", 32'(a_done), 32'd1);
        cyc();
        chk("t3_idle", 32'(a_state), 32'd0);

        // Abort at pixel 50 with tvalid held high
        a_go = 1; cyc(); a_go = 0;
        for (int i = 0; i < 50; i++) send_a(i, 1'b0, i != 49);
        a_tdata = PW'(50); a_tvalid = 1; a_abort = 1;
        @(negedge aclk);
        mon();
        chk("t5_abort_no_ready", 32'(a_tready), 32'd0);
        chk("t5_abort_no_write", 32'(a_ena), 32'd0);
        @(posedge aclk);
        #1;
        a_abort = 0;
        chk("t5_idle", 32'(a_state), 32'd0);
        chk("t5_idle_no_ready", 32'(a_tready), 32'd0);
        chk("t5_idle_no_write", 32'(a_ena), 32'd0);
        chk("t5_err_kept", 32'(a_err), 32'd0);
        chk("t5_queue", 32'(exp_q.size()), 32'd0);
        a_go = 1; cyc(); a_go = 0;
        chk("t5_restart", 32'(a_state), 32'd1);
        for (int i = 0; i < 4; i++) send_a(i, 1'b0, i != 3);
        a_abort = 1; a_tvalid = 0; cyc(); a_abort = 0;
        chk("t5_idle2", 32'(a_state), 32'd0);
        chk("t5_restart_writes", 32'(exp_q.size()), 32'd0);

        // Timeout with TMO_W=4
        b_go = 1; cyc(); b_go = 0;
        for (int i = 0; i < BPIX; i++) send_b(i, i == BPIX - 1);
        b_tvalid = 0; b_tlast = 0;
        wait_b("t4_wait_scale", 3'd3, 10);
        n = 0;
        while (b_err !== 2'b10 && n < 40) begin
            cyc();
            n++;
        end
        chk("t4_timeout_cycles", 32'(n), 32'd15);
        chk("t4_err_state", 32'(b_state), 32'd6);
        chk("t4_not_busy", 32'(b_busy), 32'd0);

        // Reset pulse in WAIT_HOG
        b_go = 1; cyc(); b_go = 0;
        chk("t6_err_cleared", 32'(b_err), 32'd0);
        for (int i = 0; i < BPIX; i++) send_b(i, i == BPIX - 1);
        b_tvalid = 0; b_tlast = 0;
        wait_b("t6_wait_scale", 3'd3, 10);
        b_sf = 1; cyc(); b_sf = 0;
        chk("t6_wait_hog", 32'(b_state), 32'd4);
        cyc(); cyc();
        chk("t6_addr_before_rst", 32'({b_addr, b_din}), 32'({AW'(3), PW'(15)}));
        #2;
        b_rst_n = 0;
        #1;
        chk("t6_rst_state", 32'(b_state), 32'd0);
        chk("t6_rst_flags", 32'({b_busy, b_tready, b_start, b_done, b_err, b_ena, b_wea}), 32'd0);
        chk("t6_rst_addr_data", 32'({b_addr, b_din}), 32'd0);
        @(posedge aclk);
        #1;
        b_rst_n = 1;
        cyc();
        chk("t6_idle_after", 32'(b_state), 32'd0);
        b_go = 1; cyc(); b_go = 0;
        chk("t6_go_accepted", 32'(b_state), 32'd1);
        chk("t6_busy", 32'(b_busy), 32'd1);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hog_frame_sequencer.md
HOG_FRAME_SEQUENCER -- requirements
Module: hog_frame_sequencer

Interface
REQ-001 SHALL have parameter RAM_AW, default 17, meaning the bank address width.
REQ-002 SHALL have parameter P_WIDTH, default 8, meaning the pixel width.
REQ-003 SHALL have parameter IMG_W, default 136, meaning the frame width in pixels (multiple of 4).
REQ-004 SHALL have parameter IMG_H, default 136, meaning the frame height in pixels.
REQ-005 SHALL have parameter TMO_W, default 24, meaning the width of the timeout counter.
REQ-006 SHALL have port aclk, input, 1 bit: the only clock, all logic on its rising edge.
REQ-007 SHALL have port arest_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have port go, input, 1 bit: a one-cycle request to process one frame.
REQ-009 SHALL have port abort, input, 1 bit: a level that forces return to IDLE.
REQ-010 SHALL have port s_tdata, input, P_WIDTH bits: raster pixel stream data.
REQ-011 SHALL have ports s_tvalid (input, 1 bit), s_tready (output, 1 bit) and s_tlast (input, 1 bit) as the stream handshake.
REQ-012 SHALL have ports init_ena and init_wea, outputs, 4 bits each: per-bank enable and write enable.
REQ-013 SHALL have ports init_addra (output, RAM_AW bits) and init_dina (output, P_WIDTH bits): shared bank write address and data.
REQ-014 SHALL have port start, output, 1 bit: scaler start pulse.
REQ-015 SHALL have ports scaling_finish and write_feature_done, inputs, 1 bit each: completion pulses from the datapath.
REQ-016 SHALL have ports busy (output, 1 bit), done (output, 1 bit pulse) and state (output, 3 bits).
REQ-017 SHALL have port err, output, 2 bits: bit0 = stream length error, bit1 = timeout.

Function
REQ-018 SHALL implement the FSM IDLE(0), LOAD(1), KICK(2), WAIT_SCALE(3), WAIT_HOG(4), DONE(5), ERR(6), with the encoding driven on state.
REQ-019 SHALL, in IDLE, move to LOAD on go, clear err and the pixel counters, and ignore go in every other state.
REQ-020 SHALL, in LOAD, assert s_tready combinationally; s_tready SHALL be 0 in every other state.
REQ-021 SHALL, on each LOAD handshake at column c and row r, write s_tdata to bank c%4 at address r*(IMG_W/4)+c/4, registered one cycle after the handshake.
REQ-022 SHALL hold exactly one bit of init_ena and init_wea high for that single cycle, and all bits low otherwise.
REQ-023 SHALL wrap the column counter at IMG_W-1 to 0 and increment the row counter on that wrap.
REQ-024 SHALL detect a length error when s_tlast=1 before pixel IMG_W*IMG_H-1, or s_tlast=0 on that pixel; it SHALL then set err[0] and go to ERR.
REQ-025 SHALL still perform the write of the offending pixel on a length error.
REQ-026 SHALL go from LOAD to KICK after the last pixel with s_tlast=1, once the final bank write has issued.
REQ-027 SHALL, in KICK, assert start for exactly one cycle and go to WAIT_SCALE.
REQ-028 SHALL, in WAIT_SCALE, go to WAIT_HOG on scaling_finish.
REQ-029 SHALL latch a write_feature_done seen in WAIT_SCALE (including one coincident with scaling_finish) and, in that case, go directly to DONE.
REQ-030 SHALL, in WAIT_HOG, go to DONE on write_feature_done or on the latched flag.
REQ-031 SHALL clear the timeout counter on WAIT_SCALE entry and increment it every cycle in WAIT_SCALE and WAIT_HOG.
REQ-032 SHALL, when the timeout counter reaches all-ones, set err[1] and go to ERR.
REQ-033 SHALL pulse done for one cycle in DONE and then return to IDLE.
REQ-034 SHALL keep ERR until go, then clear err and enter LOAD.
REQ-035 SHALL, on abort in any state, return to IDLE the next cycle with no bank write or start issued that cycle, leaving err unchanged; abort SHALL have priority over all other transitions.
REQ-036 SHALL drive busy high in LOAD, KICK, WAIT_SCALE and WAIT_HOG.

Reset
REQ-037 SHALL, on arest_n=0, immediately force state=IDLE.
REQ-038 SHALL, on arest_n=0, force s_tready, init_ena, init_wea, start, done and busy to 0.
REQ-039 SHALL, on arest_n=0, force err, init_addra, init_dina, all counters and the latched flag to 0.
REQ-040 SHALL treat a reset mid-LOAD as discarding the frame, with no further bank writes.

Verification
REQ-041 SHALL cover: go, 18496 pixels with s_tdata=i%256 and tlast on the last -> bank3 addr 33 holds pixel 135; start pulses once; scaling_finish then write_feature_done -> done pulse, state=0.
REQ-042 SHALL cover: tlast on pixel 100 -> err=01, state=6, pixel 100 written to bank0 addr 25, no start.
REQ-043 SHALL cover: scaling_finish and write_feature_done in the same cycle -> WAIT_HOG skipped, done next cycle.
REQ-044 SHALL cover: TMO_W=4 with no scaling_finish -> err=10 exactly 15 cycles after WAIT_SCALE entry.
REQ-045 SHALL cover: abort at pixel 50 with tvalid still high -> IDLE next cycle, s_tready=0, init_ena=0; a later go restarts at bank0 addr 0.
REQ-046 SHALL cover: arest_n low for one cycle mid-WAIT_HOG -> all outputs 0 asynchronously, go accepted after release.
